// File: rtl/display_pkg.sv
// display_pkg -- shared defaults for the multiplexed display scanner.
//   DEF_N_DIGITS / DEF_DIGIT_W / DEF_SCAN_DIV / DEF_PWM_W : default parameters
//   idx_width(n) : bits needed to index n items (never less than 1)
package display_pkg;

   localparam int DEF_N_DIGITS = 8;
   localparam int DEF_DIGIT_W  = 4;
   localparam int DEF_SCAN_DIV = 50000;
   localparam int DEF_PWM_W    = 4;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/scan_timer.sv
// scan_timer -- digit-advance prescaler plus brightness PWM counter.
//   clk, reset_n : clock, asynchronous active-low reset
//   bright       : PWM duty, 0 = never lit
//   adv          : combinational, high in the cycle whose closing edge advances the digit
//   scan_tick    : registered, high for the first cycle of each newly selected digit
//   lit          : combinational, PWM says the display may be lit this cycle
module scan_timer
   import display_pkg::*;
#(
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   parameter int PWM_W    = DEF_PWM_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [PWM_W-1:0] bright,
   output logic             adv,
   output logic             scan_tick,
   output logic             lit
);

   localparam int                 PRESC_W    = idx_width(SCAN_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SCAN_DIV - 1);

   logic [PRESC_W-1:0] presc_r;
   logic [PWM_W-1:0]   pwm_cnt_r;
   logic               scan_tick_r;
   logic               adv_s;
   logic               lit_s;

   // Decode prescaler terminal count and PWM duty comparison.
   always_comb begin
      adv_s = 1'b0;
      lit_s = 1'b0;
      if (presc_r == PRESC_LAST) begin
         adv_s = 1'b1;
      end else begin
         adv_s = 1'b0;
      end
      if (pwm_cnt_r < bright) begin
         lit_s = 1'b1;
      end else begin
         lit_s = 1'b0;
      end
   end

   // Prescaler (wraps at SCAN_DIV-1), free-running PWM counter, tick register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_r     <= {PRESC_W{1'b0}};
         pwm_cnt_r   <= {PWM_W{1'b0}};
         scan_tick_r <= 1'b0;
      end else begin
         if (adv_s) begin
            presc_r <= {PRESC_W{1'b0}};
         end else begin
            presc_r <= presc_r + PRESC_W'(1);
         end
         pwm_cnt_r   <= pwm_cnt_r + PWM_W'(1);
         scan_tick_r <= adv_s;
      end
   end

   assign adv       = adv_s;
   assign lit       = lit_s;
   assign scan_tick = scan_tick_r;

endmodule

// File: rtl/display_scan_mem.sv
// display_scan_mem -- digit store with time-multiplexed, PWM-dimmed scan output.
//   clk, reset_n : clock, asynchronous active-low reset
//   wr_en, wr_data, wr_mask : masked write of packed digits
//   blank_mask   : per-digit force-dark
//   bright       : PWM brightness, 0 = off
//   an_n         : one-cold digit select (all ones = dark)
//   digit        : stored value of the selected digit
//   digit_idx    : index of the selected digit
//   scan_tick    : one-cycle pulse in the first cycle of each new digit
module display_scan_mem
   import display_pkg::*;
#(
   parameter int N_DIGITS = DEF_N_DIGITS,
   parameter int DIGIT_W  = DEF_DIGIT_W,
   parameter int SCAN_DIV = DEF_SCAN_DIV,
   parameter int PWM_W    = DEF_PWM_W
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               wr_en,
   input  logic [N_DIGITS*DIGIT_W-1:0]        wr_data,
   input  logic [N_DIGITS-1:0]                wr_mask,
   input  logic [N_DIGITS-1:0]                blank_mask,
   input  logic [PWM_W-1:0]                   bright,
   output logic [N_DIGITS-1:0]                an_n,
   output logic [DIGIT_W-1:0]                 digit,
   output logic [idx_width(N_DIGITS)-1:0]     digit_idx,
   output logic                               scan_tick
);

   localparam int               IDX_W    = idx_width(N_DIGITS);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

   logic [DIGIT_W-1:0]          mem_r [N_DIGITS];
   logic                        wr_en_r;
   logic [N_DIGITS*DIGIT_W-1:0] wr_data_r;
   logic [N_DIGITS-1:0]         wr_mask_r;
   logic [IDX_W-1:0]            idx_r;
   logic [IDX_W-1:0]            idx_next_s;
   logic [N_DIGITS-1:0]         an_r;
   logic [N_DIGITS-1:0]         an_next_s;
   logic [DIGIT_W-1:0]          digit_r;
   logic                        adv_s;
   logic                        lit_s;

   scan_timer #(
      .SCAN_DIV (SCAN_DIV),
      .PWM_W    (PWM_W)
   ) u_scan_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .bright    (bright),
      .adv       (adv_s),
      .scan_tick (scan_tick),
      .lit       (lit_s)
   );

   // Next digit index (explicit wrap for non-power-of-two counts) and next select.
   // The advance cycle is forced dark so outgoing and incoming digits never overlap;
   // outside it idx_r already equals the next index, keeping an_n and digit_idx aligned.
   always_comb begin
      idx_next_s = idx_r;
      an_next_s  = {N_DIGITS{1'b1}};
      if (adv_s) begin
         if (idx_r == IDX_LAST) begin
            idx_next_s = {IDX_W{1'b0}};
         end else begin
            idx_next_s = idx_r + IDX_W'(1);
         end
      end else begin
         idx_next_s = idx_r;
         if (lit_s && !blank_mask[idx_r]) begin
            an_next_s[idx_r] = 1'b0;
         end else begin
            an_next_s = {N_DIGITS{1'b1}};
         end
      end
   end

   // Write capture stage: a write is committed to the store one edge after sampling,
   // which with the output register gives the two-clock write-to-display latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_en_r   <= 1'b0;
         wr_data_r <= {(N_DIGITS*DIGIT_W){1'b0}};
         wr_mask_r <= {N_DIGITS{1'b0}};
      end else begin
         wr_en_r   <= wr_en;
         wr_data_r <= wr_data;
         wr_mask_r <= wr_mask;
      end
   end

   // Digit store: masked per-digit update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            mem_r[k] <= {DIGIT_W{1'b0}};
         end
      end else begin
         for (int k = 0; k < N_DIGITS; k++) begin
            if (wr_en_r && wr_mask_r[k]) begin
               mem_r[k] <= wr_data_r[k*DIGIT_W +: DIGIT_W];
            end
         end
      end
   end

   // Output registers: index, select and digit value all refer to the same digit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx_r   <= {IDX_W{1'b0}};
         an_r    <= {N_DIGITS{1'b1}};
         digit_r <= {DIGIT_W{1'b0}};
      end else begin
         idx_r   <= idx_next_s;
         an_r    <= an_next_s;
         digit_r <= mem_r[idx_next_s];
      end
   end

   assign digit_idx = idx_r;
   assign an_n      = an_r;
   assign digit     = digit_r;

endmodule

// File: tb/tb_display_scan_mem.sv
// Testbench for display_scan_mem: two instances (8 digits / SCAN_DIV 4 and
// 6 digits / SCAN_DIV 3) driven by shared stimulus and compared every cycle
// against a reference model computed from elapsed edges since reset.
module tb_display_scan_mem;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        wr_en = 1'b0;
   logic [31:0] wr_data = 32'h0;
   logic [7:0]  wr_mask = 8'h0;
   logic [7:0]  blank_mask = 8'h0;
   logic [3:0]  bright = 4'hF;

   logic [7:0]  an8;
   logic [3:0]  digit8;
   logic [2:0]  idx8;
   logic        tick8;
   logic [5:0]  an6;
   logic [3:0]  digit6;
   logic [2:0]  idx6;
   logic        tick6;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   display_scan_mem #(.N_DIGITS(8), .DIGIT_W(4), .SCAN_DIV(4), .PWM_W(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
      .wr_mask(wr_mask), .blank_mask(blank_mask), .bright(bright),
      .an_n(an8), .digit(digit8), .digit_idx(idx8), .scan_tick(tick8)
   );

   display_scan_mem #(.N_DIGITS(6), .DIGIT_W(4), .SCAN_DIV(3), .PWM_W(4)) dut6 (
      .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data[23:0]),
      .wr_mask(wr_mask[5:0]), .blank_mask(blank_mask[5:0]), .bright(bright),
      .an_n(an6), .digit(digit6), .digit_idx(idx6), .scan_tick(tick6)
   );

   // ---------------- reference model ----------------
   int          e_cnt;                 // rising edges since reset release
   logic [3:0]  mem_m [2][8];
   logic        p1_en, p2_en;          // writes sampled 1 and 2 edges ago
   logic [31:0] p1_data, p2_data;
   logic [7:0]  p1_mask, p2_mask;
   logic [31:0] exp_digit [2];
   logic [31:0] exp_idx [2];
   logic [31:0] exp_an [2];
   logic [31:0] exp_tick [2];

   function automatic int n_of(input int d);
      return (d == 0) ? 8 : 6;
   endfunction

   function automatic int sd_of(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   task automatic model_reset();
      e_cnt = 0;
      p1_en = 1'b0; p2_en = 1'b0;
      p1_data = 32'h0; p2_data = 32'h0;
      p1_mask = 8'h0; p2_mask = 8'h0;
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 8; k++) mem_m[d][k] = 4'h0;
         exp_digit[d] = 32'h0;
         exp_idx[d]   = 32'h0;
         exp_an[d]    = (32'h1 << n_of(d)) - 32'h1;
         exp_tick[d]  = 32'h0;
      end
   endtask

   task automatic model_edge();
      int n, sd, idx;
      bit tick, lit;
      logic [31:0] an;
      if (!reset_n) begin
         model_reset();
         return;
      end
      e_cnt++;
      // a write sampled two edges ago is what the display reflects now
      if (p2_en) begin
         for (int d = 0; d < 2; d++)
            for (int k = 0; k < n_of(d); k++)
               if (p2_mask[k]) mem_m[d][k] = p2_data[k*4 +: 4];
      end
      for (int d = 0; d < 2; d++) begin
         n    = n_of(d);
         sd   = sd_of(d);
         idx  = (e_cnt / sd) % n;
         tick = (e_cnt % sd) == 0;
         lit  = ((e_cnt - 1) % 16) < int'(bright);
         an   = (32'h1 << n) - 32'h1;
         if (!tick && lit && !blank_mask[idx]) an = an & ~(32'h1 << idx);
         exp_idx[d]   = 32'(idx);
         exp_tick[d]  = tick ? 32'h1 : 32'h0;
         exp_an[d]    = an;
         exp_digit[d] = 32'(mem_m[d][idx]);
      end
      p2_en = p1_en; p2_data = p1_data; p2_mask = p1_mask;
      p1_en = wr_en; p1_data = wr_data; p1_mask = wr_mask;
   endtask

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      check_val("d8_digit", 32'(digit8), exp_digit[0]);
      check_val("d8_idx",   32'(idx8),   exp_idx[0]);
      check_val("d8_an",    32'(an8),    exp_an[0]);
      check_val("d8_tick",  32'(tick8),  exp_tick[0]);
      check_val("d6_digit", 32'(digit6), exp_digit[1]);
      check_val("d6_idx",   32'(idx6),   exp_idx[1]);
      check_val("d6_an",    32'(an6),    exp_an[1]);
      check_val("d6_tick",  32'(tick6),  exp_tick[1]);
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic drive_write(input logic [31:0] data, input logic [7:0] mask);
      wr_en = 1'b1; wr_data = data; wr_mask = mask;
      step();
      wr_en = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      run(3);                                  // edges while held in reset
      @(negedge clk); reset_n = 1'b1;
      run(40);                                 // plain scan, full brightness
      drive_write(32'h87654321, 8'hFF); run(40);
      drive_write(32'hAAAAAAAA, 8'h0C); run(40);
      wr_en = 1'b0; wr_data = 32'hFFFFFFFF; wr_mask = 8'hFF; run(10);   // ignored data
      bright = 4'h0; run(20);
      bright = 4'h8; run(40);
      bright = 4'hF;
      blank_mask = 8'h01; run(40);
      blank_mask = 8'h00;
      for (int i = 0; i < 400; i++) begin
         wr_en      = ($urandom_range(0, 3) == 0);
         wr_data    = $urandom;
         wr_mask    = 8'($urandom);
         blank_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
         bright     = 4'($urandom);
         step();
      end
      wr_en = 1'b0; blank_mask = 8'h00; bright = 4'hF;
      drive_write(32'h13572468, 8'hFF); run(5);
      drive_write(32'h9ABCDEF0, 8'hFF);        // write in flight when reset hits
      @(negedge clk); reset_n = 1'b0;
      #1; model_reset(); compare_all();        // asynchronous clear
      wr_en = 1'b1; wr_data = 32'h55555555; wr_mask = 8'hFF;
      run(2);
      @(negedge clk); reset_n = 1'b1; wr_en = 1'b0;
      run(40);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan_mem.md
DISPLAY_SCAN_MEM -- requirements
Module: display_scan_mem

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 8, giving the number of display digits, legal range 2..16.
REQ-002 The block SHALL have parameter DIGIT_W, default 4, giving the bits per stored digit.
REQ-003 The block SHALL have parameter SCAN_DIV, default 50000, giving the clocks each digit is selected, minimum 2.
REQ-004 The block SHALL have parameter PWM_W, default 4, giving the brightness resolution in bits.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk  in  1  rising-edge clock.
REQ-006 reset_n  in  1  asynchronous active-low reset.
REQ-007 wr_en  in  1  write strobe, sampled on the rising clk edge.
REQ-008 wr_data  in  N_DIGITS*DIGIT_W  packed digits; digit k occupies bits [k*DIGIT_W +: DIGIT_W].
REQ-009 wr_mask  in  N_DIGITS  per-digit write enable; bit k gates digit k.
REQ-010 blank_mask  in  N_DIGITS  bit k=1 forces digit k dark.
REQ-011 bright  in  PWM_W  brightness duty, 0=off.
REQ-012 an_n  out  N_DIGITS  one-cold digit select; all ones=dark.
REQ-013 digit  out  DIGIT_W  stored value of the selected digit.
REQ-014 digit_idx  out  clog2(N_DIGITS)  index of the selected digit.
REQ-015 scan_tick  out  1  one-clock pulse on each digit advance.

Function
REQ-016 A write SHALL occur on a clk edge with wr_en=1 and SHALL update only the digits whose wr_mask bit is 1; the other digits keep their values.
REQ-017 When wr_en=0, wr_data and wr_mask SHALL be ignored.
REQ-018 A prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; at the terminal count, digit_idx SHALL advance by one.
REQ-019 digit_idx SHALL wrap from N_DIGITS-1 to 0, including when N_DIGITS is not a power of two.
REQ-020 scan_tick SHALL be 1 for exactly the clock in which digit_idx changes.
REQ-021 A PWM counter SHALL increment every clock modulo 2^PWM_W; the display SHALL be lit while pwm_cnt < bright.
REQ-022 With bright=0, an_n SHALL remain all ones; with bright=2^PWM_W-1, an_n SHALL be dark exactly 1 of every 2^PWM_W clocks.
REQ-023 an_n SHALL drive bit digit_idx low only when the display is lit and blank_mask[digit_idx]=0; otherwise all an_n bits SHALL be 1.
REQ-024 an_n SHALL force all ones for the first clock after every digit_idx change, so that no two digits overlap.
REQ-025 digit, an_n and digit_idx SHALL be registered outputs, consistent with each other in every cycle.
REQ-026 Write-to-display latency SHALL be 2 clocks: after a write to the selected digit at edge t, digit SHALL show the new value after edge t+2.
REQ-027 A write that coincides with a scan advance SHALL complete normally, with neither the write nor the advance lost.
REQ-028 blank_mask and bright SHALL take effect with 1 clock of latency.

Reset
REQ-029 While reset_n=0, the block SHALL clear asynchronously: all stored digits=0, prescaler=0, pwm_cnt=0, digit_idx=0, digit=0, an_n=all ones, scan_tick=0.
REQ-030 Reset applied mid-scan or mid-write SHALL abort the operation; no partial write SHALL survive.
REQ-031 After reset_n rises, the first scan_tick SHALL occur SCAN_DIV clocks later.

Structure
REQ-032 Shared package display_pkg SHALL hold the default constants (N_DIGITS, DIGIT_W, SCAN_DIV, PWM_W) and the clog2-based index-width function.
REQ-033 The prescaler plus PWM counter SHALL be one sub-module, scan_timer, producing scan_tick and lit; the storage, mux and output registers SHALL stay in the top level.
REQ-034 The digit mux SHALL be indexed by digit_idx, not decoded from an_n.

Verification
REQ-035 Reset release with N_DIGITS=8, SCAN_DIV=4, bright=15 -> digit=0 and an_n cycles FE,FD,...,7F; a new digit is selected every 4 clocks, and the sequence wraps to FE.
REQ-036 Write wr_data=32'h87654321, wr_mask=8'hFF -> digit shows 1..8 as digit_idx runs 0..7.
REQ-037 Write 32'hAAAAAAAA with wr_mask=8'h0C after the REQ-036 write -> only digits 2 and 3 read A; the other digits are unchanged.
REQ-038 bright=0 -> an_n=FF always; bright=8 with PWM_W=4 -> lit 8 of every 16 clocks, plus a dark clock after each advance.
REQ-039 blank_mask=8'h01 -> an_n=FF while digit_idx=0; the other digits display normally.
REQ-040 N_DIGITS=6; pulse reset_n low mid-scan after a write -> digits read 0, digit_idx=0, an_n=FF during reset, and idx wraps 5->0.
